// File: rtl/bram_weight_writer_if.sv
// Single-port BRAM bus shared by the weight writer (master) and the BRAM or its model (slave).
interface bram_weight_writer_if #(
  parameter int unsigned W          = 8,
  parameter int unsigned ADDR_WIDTH = 18
);
  logic                  bram_en;
  logic                  bram_wen;
  logic                  bram_ren;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [W-1:0]          bram_din;
  logic [W-1:0]          bram_dout;

  modport master (
    output bram_en,
    output bram_wen,
    output bram_ren,
    output bram_addr,
    output bram_din,
    input  bram_dout
  );

  modport slave (
    input  bram_en,
    input  bram_wen,
    input  bram_ren,
    input  bram_addr,
    input  bram_din,
    output bram_dout
  );
endinterface

// File: rtl/bram_weight_writer.sv
// Snapshots a flat element vector, writes it into BRAM from BASE_ADDR upward and optionally
// reads the region back, counting mismatches against the snapshot.
module bram_weight_writer #(
  parameter int unsigned N_ELEMS      = 8,
  parameter int unsigned W            = 8,
  parameter int unsigned ADDR_WIDTH   = 18,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned VERIFY_EN    = 1,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_ELEMS*W-1:0]   data_in,
  bram_weight_writer_if.master   bram,
  output logic                   busy,
  output logic                   done,
  output logic                   mismatch,
  output logic [CNT_W-1:0]       mismatch_count,
  output logic [CNT_W-1:0]       first_err_idx
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWrite  = 2'd1;
  localparam logic [1:0] StVerify = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam int unsigned           IdxW    = $clog2(N_ELEMS + 1);
  localparam logic [IdxW-1:0]       LastIdx = IdxW'(N_ELEMS - 1);
  // One past the last element: marks the single tail cycle before DONE when verify is off.
  localparam logic [IdxW-1:0]       TailIdx = IdxW'(N_ELEMS);
  localparam logic [ADDR_WIDTH-1:0] Base    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CNT_W-1:0]      CntMax  = {CNT_W{1'b1}};

  if (longint'(BASE_ADDR) + longint'(N_ELEMS) > (longint'(1) << ADDR_WIDTH)) begin : g_wrap_warn
    $warning("bram_weight_writer: region wraps past the top of the address space");
  end

  logic [1:0]             state_q, state_d;
  logic [N_ELEMS*W-1:0]   snap_q, snap_d;
  logic [IdxW-1:0]        wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]        rd_idx_q, rd_idx_d;
  logic                   en_q, en_d, wen_q, wen_d, ren_q, ren_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [W-1:0]           din_q, din_d;
  logic                   busy_q, busy_d, done_q, done_d, mismatch_q, mismatch_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, first_q, first_d;
  logic [READ_LATENCY-1:0] tag_vld_q;
  logic [IdxW-1:0]        tag_idx_q [READ_LATENCY];
  logic [IdxW-1:0]        nxt_idx;

  function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [IdxW-1:0] i);
    return Base + ADDR_WIDTH'(i);
  endfunction

  function automatic logic [W-1:0] elem(input logic [IdxW-1:0] i);
    return snap_q[i*W +: W];
  endfunction

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    en_d       = en_q;
    wen_d      = wen_q;
    ren_d      = ren_q;
    addr_d     = addr_q;
    din_d      = din_q;
    busy_d     = busy_q;
    done_d     = done_q;
    mismatch_d = mismatch_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    nxt_idx    = '0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StWrite;
          snap_d     = data_in;
          wr_idx_d   = '0;
          en_d       = 1'b1;
          wen_d      = 1'b1;
          ren_d      = 1'b0;
          addr_d     = Base;
          din_d      = data_in[W-1:0];
          busy_d     = 1'b1;
          done_d     = 1'b0;
          mismatch_d = 1'b0;
          cnt_d      = '0;
          first_d    = '0;
        end
      end
      StWrite: begin
        if (wr_idx_q == TailIdx) begin
          state_d    = StDone;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          mismatch_d = 1'b0;
        end else if (wr_idx_q == LastIdx) begin
          if (VERIFY_EN != 0) begin
            state_d  = StVerify;
            wen_d    = 1'b0;
            ren_d    = 1'b1;
            rd_idx_d = '0;
            addr_d   = Base;
          end else begin
            en_d     = 1'b0;
            wen_d    = 1'b0;
            wr_idx_d = TailIdx;
          end
        end else begin
          nxt_idx  = wr_idx_q + 1'b1;
          wr_idx_d = nxt_idx;
          addr_d   = elem_addr(nxt_idx);
          din_d    = elem(nxt_idx);
        end
      end
      StVerify: begin
        if (ren_q) begin
          if (rd_idx_q == LastIdx) begin
            en_d  = 1'b0;
            ren_d = 1'b0;
          end else begin
            nxt_idx  = rd_idx_q + 1'b1;
            rd_idx_d = nxt_idx;
            addr_d   = elem_addr(nxt_idx);
          end
        end
        if (tag_vld_q[READ_LATENCY-1] &&
            (bram.bram_dout != elem(tag_idx_q[READ_LATENCY-1]))) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) first_d = CNT_W'(tag_idx_q[READ_LATENCY-1]);
        end
        // Reads all issued and every tag has emerged: the last compare happened last edge.
        if (!ren_q && (tag_vld_q == '0)) begin
          state_d    = StDone;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          mismatch_d = (cnt_q != '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      snap_q     <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      en_q       <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      addr_q     <= Base;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
      first_q    <= '0;
      tag_vld_q  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) tag_idx_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      en_q       <= en_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      // Tag follows the read presented on the bus so it lines up with bram_dout.
      tag_vld_q[0] <= ren_q;
      tag_idx_q[0] <= rd_idx_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  assign bram.bram_en   = en_q;
  assign bram.bram_wen  = wen_q;
  assign bram.bram_ren  = ren_q;
  assign bram.bram_addr = addr_q;
  assign bram.bram_din  = din_q;

  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch       = mismatch_q;
  assign mismatch_count = cnt_q;
  assign first_err_idx  = first_q;

endmodule

// File: tb/tb_bram_weight_writer.sv
// Three writers (default, high base with a corrupted readback word, verify off) on one shared
// BRAM model, checked every cycle against a transfer-level model of the expected bus activity.
module tb_bram_weight_writer;
  localparam int N       = 8;
  localparam int RL      = 2;
  localparam int CORRUPT = 110595;
  localparam int BASE_M [3] = '{0, 110592, 0};
  localparam int VEN_M  [3] = '{1, 1, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [63:0] data_in;
  logic [2:0]  busy_s, done_s, mis_s;
  logic [15:0] cnt_s [3];
  logic [15:0] first_s [3];
  logic [2:0]  en_s, wen_s, ren_s;
  logic [17:0] addr_s [3];
  logic [7:0]  din_s [3];
  logic [7:0]  rd0, rd1;
  logic [7:0]  mem [0:262143];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  bit          chk_on = 1'b0;
  int          m_q [3] = '{-1, -1, -1};
  logic [63:0] snap_m [3];

  always #5 clk = ~clk;

  bram_weight_writer_if #(.W(8), .ADDR_WIDTH(18)) bif0 ();
  bram_weight_writer_if #(.W(8), .ADDR_WIDTH(18)) bif1 ();
  bram_weight_writer_if #(.W(8), .ADDR_WIDTH(18)) bif2 ();

  bram_weight_writer #(.BASE_ADDR(0), .VERIFY_EN(1)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .data_in(data_in), .bram(bif0),
    .busy(busy_s[0]), .done(done_s[0]), .mismatch(mis_s[0]),
    .mismatch_count(cnt_s[0]), .first_err_idx(first_s[0]));
  bram_weight_writer #(.BASE_ADDR(110592), .VERIFY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .data_in(data_in), .bram(bif1),
    .busy(busy_s[1]), .done(done_s[1]), .mismatch(mis_s[1]),
    .mismatch_count(cnt_s[1]), .first_err_idx(first_s[1]));
  bram_weight_writer #(.BASE_ADDR(0), .VERIFY_EN(0)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .data_in(data_in), .bram(bif2),
    .busy(busy_s[2]), .done(done_s[2]), .mismatch(mis_s[2]),
    .mismatch_count(cnt_s[2]), .first_err_idx(first_s[2]));

  assign en_s   = {bif2.bram_en, bif1.bram_en, bif0.bram_en};
  assign wen_s  = {bif2.bram_wen, bif1.bram_wen, bif0.bram_wen};
  assign ren_s  = {bif2.bram_ren, bif1.bram_ren, bif0.bram_ren};
  assign addr_s[0] = bif0.bram_addr;
  assign addr_s[1] = bif1.bram_addr;
  assign addr_s[2] = bif2.bram_addr;
  assign din_s[0]  = bif0.bram_din;
  assign din_s[1]  = bif1.bram_din;
  assign din_s[2]  = bif2.bram_din;
  assign bif0.bram_dout = rd1;
  assign bif1.bram_dout = rd1;
  assign bif2.bram_dout = rd1;

  // Shared BRAM: writes land on the edge, read data appears RL edges after the address.
  always @(posedge clk) begin
    logic        hit;
    logic [17:0] ra;
    hit = 1'b0;
    ra  = '0;
    for (int d = 0; d < 3; d++) begin
      if (en_s[d] === 1'b1 && wen_s[d] === 1'b1) begin
        mem[addr_s[d]] = din_s[d];
        n_writes++;
      end
      if (en_s[d] === 1'b1 && ren_s[d] === 1'b1) begin
        hit = 1'b1;
        ra  = addr_s[d];
      end
    end
    rd0 <= hit ? ((int'(ra) == CORRUPT) ? 8'hFF : mem[ra]) : 8'h00;
    rd1 <= rd0;
    cyc <= cyc + 1;
  end

  function automatic int done_at(input int d);
    return (VEN_M[d] != 0) ? 2 * N + RL + 1 : N + 1;
  endfunction

  // Transfer model: m = edges since the accepted start, -1 when idle after reset.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) m_q[d] = -1;
      else if (m_q[d] < 0 || m_q[d] >= done_at(d)) begin
        if (start[d]) begin
          snap_m[d] = data_in;
          m_q[d]    = 0;
        end
      end else m_q[d]++;
    end
  end

  task automatic chk(input string name, input int d, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
    end
  endtask

  task automatic check_dut(input int d);
    int          m, dm, ncmp, ecnt, efirst;
    logic        e_en, e_wen, e_ren, e_busy, e_done, e_mis;
    logic [17:0] e_addr;
    logic [7:0]  e_din, b;
    bit          ck_addr, ck_din;
    m = m_q[d];
    dm = done_at(d);
    e_en = 0; e_wen = 0; e_ren = 0; e_busy = 0; e_done = 0;
    e_addr = 18'(BASE_M[d]); e_din = 8'h00; ck_addr = 1; ck_din = 0;
    if (m < 0) ck_din = 1;
    else if (m < N) begin
      e_en = 1; e_wen = 1; e_busy = 1; ck_din = 1;
      e_addr = 18'(BASE_M[d] + m);
      e_din  = snap_m[d][8*m +: 8];
    end else if (VEN_M[d] != 0 && m < 2 * N) begin
      e_en = 1; e_ren = 1; e_busy = 1;
      e_addr = 18'(BASE_M[d] + m - N);
    end else if (m < dm) begin
      e_busy = 1; ck_addr = 0;
    end else begin
      e_done = 1;
      e_addr = 18'(BASE_M[d] + N - 1);
    end
    // Readback i is compared N+RL+1 edges after start+i; only the corrupted word can differ.
    ncmp = (VEN_M[d] != 0 && m >= 0) ? m - N - RL : 0;
    if (ncmp < 0) ncmp = 0;
    if (ncmp > N) ncmp = N;
    ecnt = 0; efirst = 0;
    for (int i = 0; i < ncmp; i++) begin
      b = snap_m[d][8*i +: 8];
      if (BASE_M[d] + i == CORRUPT && b != 8'hFF) begin
        if (ecnt == 0) efirst = i;
        ecnt++;
      end
    end
    e_mis = e_done && (ecnt != 0);
    chk("bram_en", d, 64'(en_s[d]), 64'(e_en));
    chk("bram_wen", d, 64'(wen_s[d]), 64'(e_wen));
    chk("bram_ren", d, 64'(ren_s[d]), 64'(e_ren));
    if (ck_addr) chk("bram_addr", d, 64'(addr_s[d]), 64'(e_addr));
    if (ck_din) chk("bram_din", d, 64'(din_s[d]), 64'(e_din));
    chk("busy", d, 64'(busy_s[d]), 64'(e_busy));
    chk("done", d, 64'(done_s[d]), 64'(e_done));
    chk("mismatch", d, 64'(mis_s[d]), 64'(e_mis));
    chk("mismatch_count", d, 64'(cnt_s[d]), 64'(ecnt));
    chk("first_err_idx", d, 64'(first_s[d]), 64'(efirst));
  endtask

  always @(negedge clk) begin
    if (chk_on) for (int d = 0; d < 3; d++) check_dut(d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a transfer; optionally disturb start/data_in while busy. lat = edges to done.
  task automatic run(input int d, input logic [63:0] v, input bit perturb, output int lat);
    int k;
    bit got;
    data_in  = v;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    k   = cyc;
    got = 1'b0;
    for (int j = 0; j < 100 && !got; j++) begin
      if (perturb && j == 2) begin
        data_in  = {$urandom, $urandom};
        start[d] = 1'b1;
      end
      tick();
      start[d] = 1'b0;
      if (done_s[d] === 1'b1) got = 1'b1;
    end
    chk("done_timeout", d, 64'(got), 64'(1));
    lat = cyc - k;
  endtask

  task automatic chk_region(input string name, input int d, input logic [63:0] v);
    for (int i = 0; i < N; i++) chk(name, d, 64'(mem[BASE_M[d] + i]), 64'(v[8*i +: 8]));
  endtask

  initial begin
    logic [63:0] v, old_v, new_v;
    int          lat, d;
    rst = 1'b1; start = '0; data_in = '0;
    for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
    tick();
    chk_on = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_writes", 0, 64'(n_writes), 64'(0));

    // Basic write + verify.
    run(0, 64'h0807060504030201, 1'b0, lat);
    chk("basic_latency", 0, 64'(lat), 64'(19));
    for (int i = 0; i < N; i++) chk("basic_mem", 0, 64'(mem[i]), 64'(i + 1));
    chk("basic_count", 0, 64'(cnt_s[0]), 64'(0));

    // Corrupted readback at 110595.
    run(1, 64'h0807060504030201, 1'b0, lat);
    chk("inj_latency", 1, 64'(lat), 64'(19));
    chk("inj_mismatch", 1, 64'(mis_s[1]), 64'(1));
    chk("inj_count", 1, 64'(cnt_s[1]), 64'(1));
    chk("inj_first", 1, 64'(first_s[1]), 64'(3));
    for (int i = 0; i < N; i++) chk("inj_mem", 1, 64'(mem[110592 + i]), 64'(i + 1));

    // Verify disabled, then restart from DONE.
    run(2, {$urandom, $urandom}, 1'b0, lat);
    chk("nov_latency", 2, 64'(lat), 64'(9));
    run(2, {8{8'hAA}}, 1'b0, lat);
    chk("nov_restart_latency", 2, 64'(lat), 64'(9));
    for (int i = 0; i < N; i++) chk("nov_mem", 2, 64'(mem[i]), 64'(8'hAA));

    // Start and data change while busy are ignored.
    old_v = {$urandom, $urandom};
    run(0, old_v, 1'b1, lat);
    chk("iso_latency", 0, 64'(lat), 64'(19));
    chk_region("iso_mem", 0, old_v);

    // Reset sampled on the edge that would present element 4.
    new_v    = ~old_v;
    data_in  = new_v;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wen", 0, 64'(wen_s[0]), 64'(0));
    tick();
    for (int i = 0; i < N; i++)
      chk("rst_mem", 0, 64'(mem[i]), (i < 4) ? 64'(new_v[8*i +: 8]) : 64'(old_v[8*i +: 8]));
    v = {$urandom, $urandom};
    run(0, v, 1'b0, lat);
    chk("post_rst_latency", 0, 64'(lat), 64'(19));
    chk_region("post_rst_mem", 0, v);

    // Randomized transfers across all three writers.
    for (int t = 0; t < 10; t++) begin
      d = $urandom_range(0, 2);
      v = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) v[31:24] = 8'hFF;
      repeat ($urandom_range(0, 3)) tick();
      run(d, v, 1'($urandom_range(0, 1)), lat);
      chk_region("rand_mem", d, v);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
